// File: rtl/gb80_bus_arbiter.sv
// gb80 external memory bus arbiter: one owner at a time among DMA, DBG and CPU,
// fixed priority DMA > DBG > CPU with a CPU anti-starvation override and DMA burst lock.
module gb80_bus_arbiter #(
  parameter int ACCESS_CYCLES = 1,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dma_req,
  input  logic        dbg_req,
  input  logic        cpu_req,
  input  logic        dma_we,
  input  logic        dbg_we,
  input  logic        cpu_we,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dbg_addr,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  dma_wdata,
  input  logic [7:0]  dbg_wdata,
  input  logic [7:0]  cpu_wdata,
  input  logic        dma_lock,
  output logic        dma_gnt,
  output logic        dbg_gnt,
  output logic        cpu_gnt,
  output logic        dma_done,
  output logic        dbg_done,
  output logic        cpu_done,
  output logic [7:0]  rdata,
  output logic        cpu_mem_disable,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata
);

  localparam logic [1:0] CNT_LOAD   = 2'(ACCESS_CYCLES - 1);
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_HOLD} state_t;

  state_t      r_state;
  logic [2:0]  r_gnt;        // bit 0 = DMA, 1 = DBG, 2 = CPU
  logic [2:0]  r_done;
  logic [1:0]  r_cnt;
  logic [7:0]  r_starve;
  logic [15:0] r_mem_addr;
  logic [7:0]  r_mem_wdata;
  logic        r_mem_we;
  logic        r_mem_re;
  logic [7:0]  r_rdata;

  logic [2:0]  w_req;
  logic [2:0]  w_win;
  logic        w_starved;
  logic [15:0] w_addr;
  logic [7:0]  w_wdata;
  logic        w_we;

  // A master whose done is pulsing still shows its old req; mask it out.
  assign w_req     = {cpu_req & ~r_done[2], dbg_req & ~r_done[1], dma_req & ~r_done[0]};
  assign w_starved = w_req[2] && (r_starve == STARVE_MAX);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_win   = 3'b000;
    w_addr  = cpu_addr;
    w_wdata = cpu_wdata;
    w_we    = cpu_we;
    if (w_starved)     w_win = 3'b100;
    else if (w_req[0]) w_win = 3'b001;
    else if (w_req[1]) w_win = 3'b010;
    else if (w_req[2]) w_win = 3'b100;
    if (w_win[0]) begin
      w_addr  = dma_addr;
      w_wdata = dma_wdata;
      w_we    = dma_we;
    end else if (w_win[1]) begin
      w_addr  = dbg_addr;
      w_wdata = dbg_wdata;
      w_we    = dbg_we;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_done      <= '0;
      r_cnt       <= '0;
      r_starve    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_rdata     <= '0;
    end else begin
      // NOTE: non-blocking throughout; this default is overridden below only on the last access cycle.
      r_done <= '0;

      if (!cpu_req) begin
        r_starve <= '0;
      end else if (r_state == S_IDLE && w_win != 3'b000) begin
        if (w_win[2])                 r_starve <= '0;
        else if (r_starve != STARVE_MAX) r_starve <= r_starve + 8'd1;
      end

      case (r_state)
        S_IDLE: begin
          r_gnt <= w_win;
          if (w_win != 3'b000) begin
            r_mem_addr  <= w_addr;
            r_mem_wdata <= w_wdata;
            r_mem_we    <= w_we;
            r_mem_re    <= ~w_we;
            r_cnt       <= CNT_LOAD;
            r_state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_cnt == 2'd0) begin
            if (r_mem_re) r_rdata <= mem_rdata;
            r_mem_we <= 1'b0;
            r_mem_re <= 1'b0;
            r_done   <= r_gnt;
            r_state  <= (r_gnt[0] && dma_lock) ? S_HOLD : S_IDLE;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        S_HOLD: begin
          if (dma_req && !r_done[0]) begin
            r_mem_addr  <= dma_addr;
            r_mem_wdata <= dma_wdata;
            r_mem_we    <= dma_we;
            r_mem_re    <= ~dma_we;
            r_cnt       <= CNT_LOAD;
            r_state     <= S_ACCESS;
          end else if (!dma_lock) begin
            r_gnt   <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dma_gnt         = r_gnt[0];
  assign dbg_gnt         = r_gnt[1];
  assign cpu_gnt         = r_gnt[2];
  assign dma_done        = r_done[0];
  assign dbg_done        = r_done[1];
  assign cpu_done        = r_done[2];
  assign cpu_mem_disable = r_gnt[0] | r_gnt[1];
  assign rdata           = r_rdata;
  assign mem_addr        = r_mem_addr;
  assign mem_wdata       = r_mem_wdata;
  assign mem_we          = r_mem_we;
  assign mem_re          = r_mem_re;

endmodule

// File: tb/tb_gb80_bus_arbiter.sv
// Self-checking bench for gb80_bus_arbiter: two instances (1 and 3 access cycles)
// share stimulus; per-master scoreboards are pushed at request and popped at done.
module tb_gb80_bus_arbiter;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } sb_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        sel;
  logic [2:0]  req;
  logic [2:0]  we;
  logic        dma_lock;
  logic [15:0] addr  [3];
  logic [7:0]  wdata [3];

  logic [2:0]  a_gnt, a_done, b_gnt, b_done;
  logic [7:0]  a_rdata, b_rdata, a_mem_wdata, b_mem_wdata, a_mem_rdata, b_mem_rdata;
  logic [15:0] a_mem_addr, b_mem_addr;
  logic        a_cmd, b_cmd, a_mem_we, b_mem_we, a_mem_re, b_mem_re;

  logic [2:0]  gnt, done;
  logic [7:0]  rdata, mem_wdata;
  logic [15:0] mem_addr;
  logic        cmd, mem_we, mem_re;

  int n_checks = 0;
  int n_fail   = 0;
  int we_count = 0;
  int re_count = 0;
  int lock_viol = 0;
  logic [15:0] last_waddr = '0;
  logic [7:0]  last_wdata = '0;

  sb_t q_dma[$];
  sb_t q_dbg[$];
  sb_t q_cpu[$];

  always #5 clock = ~clock;

  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'h9A;
  endfunction

  assign a_mem_rdata = mem_f(a_mem_addr);
  assign b_mem_rdata = mem_f(b_mem_addr);

  assign gnt       = sel ? b_gnt       : a_gnt;
  assign done      = sel ? b_done      : a_done;
  assign rdata     = sel ? b_rdata     : a_rdata;
  assign cmd       = sel ? b_cmd       : a_cmd;
  assign mem_addr  = sel ? b_mem_addr  : a_mem_addr;
  assign mem_wdata = sel ? b_mem_wdata : a_mem_wdata;
  assign mem_we    = sel ? b_mem_we    : a_mem_we;
  assign mem_re    = sel ? b_mem_re    : a_mem_re;

  gb80_bus_arbiter #(.ACCESS_CYCLES(1), .STARVE_LIMIT(8)) u_dut_a (
    .clock(clock), .reset(reset),
    .dma_req(req[0]), .dbg_req(req[1]), .cpu_req(req[2]),
    .dma_we(we[0]), .dbg_we(we[1]), .cpu_we(we[2]),
    .dma_addr(addr[0]), .dbg_addr(addr[1]), .cpu_addr(addr[2]),
    .dma_wdata(wdata[0]), .dbg_wdata(wdata[1]), .cpu_wdata(wdata[2]),
    .dma_lock(dma_lock),
    .dma_gnt(a_gnt[0]), .dbg_gnt(a_gnt[1]), .cpu_gnt(a_gnt[2]),
    .dma_done(a_done[0]), .dbg_done(a_done[1]), .cpu_done(a_done[2]),
    .rdata(a_rdata), .cpu_mem_disable(a_cmd),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we), .mem_re(a_mem_re),
    .mem_rdata(a_mem_rdata)
  );

  gb80_bus_arbiter #(.ACCESS_CYCLES(3), .STARVE_LIMIT(8)) u_dut_b (
    .clock(clock), .reset(reset),
    .dma_req(req[0]), .dbg_req(req[1]), .cpu_req(req[2]),
    .dma_we(we[0]), .dbg_we(we[1]), .cpu_we(we[2]),
    .dma_addr(addr[0]), .dbg_addr(addr[1]), .cpu_addr(addr[2]),
    .dma_wdata(wdata[0]), .dbg_wdata(wdata[1]), .cpu_wdata(wdata[2]),
    .dma_lock(dma_lock),
    .dma_gnt(b_gnt[0]), .dbg_gnt(b_gnt[1]), .cpu_gnt(b_gnt[2]),
    .dma_done(b_done[0]), .dbg_done(b_done[1]), .cpu_done(b_done[2]),
    .rdata(b_rdata), .cpu_mem_disable(b_cmd),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_re(b_mem_re),
    .mem_rdata(b_mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_sb(input int m, input sb_t e);
    case (m)
      0:       q_dma.push_back(e);
      1:       q_dbg.push_back(e);
      default: q_cpu.push_back(e);
    endcase
  endtask

  // Scoreboard consumer plus per-cycle bus invariants of the selected instance.
  always @(negedge clock) begin
    if (!reset) begin
      check("mem_disable", {31'd0, cmd}, {31'd0, gnt[0] | gnt[1]});
      check("gnt_onehot", {31'd0, $countones(gnt) <= 1}, 32'd1);
      if (mem_we) begin
        we_count++;
        last_waddr = mem_addr;
        last_wdata = mem_wdata;
      end
      if (mem_re) re_count++;
      if (dma_lock && gnt[2]) lock_viol++;
      for (int m = 0; m < 3; m++) begin
        if (done[m]) begin
          sb_t e;
          int  sz;
          sz = (m == 0) ? q_dma.size() : (m == 1) ? q_dbg.size() : q_cpu.size();
          if (sz == 0) begin
            check($sformatf("m%0d_spurious_done", m), 32'd1, 32'd0);
          end else begin
            case (m)
              0:       e = q_dma.pop_front();
              1:       e = q_dbg.pop_front();
              default: e = q_cpu.pop_front();
            endcase
            if (e.we) begin
              check($sformatf("m%0d_waddr", m), {16'd0, last_waddr}, {16'd0, e.addr});
              check($sformatf("m%0d_wdata", m), {24'd0, last_wdata}, {24'd0, e.data});
            end else begin
              check($sformatf("m%0d_rdata", m), {24'd0, rdata}, {24'd0, e.data});
            end
          end
        end
      end
    end
  end

  task automatic wait_done(input int m);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge clock);
      seen = done[m];
    end
    if (!seen) check($sformatf("m%0d_done_timeout", m), 32'd0, 32'd1);
  endtask

  // Requester model: holds req/payload until done, then moves straight to the next access.
  task automatic run_master(input int m, input int n, input logic w,
                            input logic [15:0] base, input logic [7:0] seed);
    sb_t e;
    for (int i = 0; i < n; i++) begin
      addr[m]  = base + 16'(i);
      wdata[m] = seed + 8'(i);
      we[m]    = w;
      req[m]   = 1'b1;
      e.we   = w;
      e.addr = addr[m];
      e.data = w ? wdata[m] : mem_f(addr[m]);
      push_sb(m, e);
      wait_done(m);
    end
    req[m] = 1'b0;
  endtask

  task automatic do_reset(input logic s);
    reset    = 1'b1;
    sel      = s;
    req      = '0;
    we       = '0;
    dma_lock = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_gnt",   {29'd0, gnt},  32'd0);
    check("rst_done",  {29'd0, done}, 32'd0);
    check("rst_rdata", {24'd0, rdata}, 32'd0);
    check("rst_mem",   {14'd0, mem_addr, mem_wdata, mem_we, mem_re}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] exp_g [6];
    logic       exp_d [6];
    int         first;
    int         snap_we, snap_re, snap_lv;

    for (int m = 0; m < 3; m++) begin
      addr[m]  = '0;
      wdata[m] = '0;
    end
    req = '0; we = '0; dma_lock = 1'b0; sel = 1'b0; reset = 1'b1;

    // CPU single read, 1-cycle access.
    do_reset(1'b0);
    fork
      run_master(2, 1, 1'b0, 16'hC000, 8'h00);
      begin
        @(negedge clock);
        check("t1_c1_gnt",  {29'd0, gnt}, 32'd4);
        check("t1_c1_re",   {31'd0, mem_re}, 32'd1);
        check("t1_c1_addr", {16'd0, mem_addr}, 32'hC000);
        @(negedge clock);
        check("t1_c2_done",  {31'd0, done[2]}, 32'd1);
        check("t1_c2_rdata", {24'd0, rdata}, 32'h5A);
        @(negedge clock);
        check("t1_c3_gnt", {31'd0, gnt[2]}, 32'd0);
      end
    join
    repeat (2) @(negedge clock);

    // Simultaneous requests: DMA, then DBG, then CPU.
    exp_g = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    fork
      run_master(0, 1, 1'b0, 16'h0100, 8'h00);
      run_master(1, 1, 1'b1, 16'h0200, 8'hA0);
      run_master(2, 1, 1'b0, 16'h0300, 8'h00);
      for (int k = 0; k < 6; k++) begin
        @(negedge clock);
        check($sformatf("t3_c%0d_gnt", k + 1), {29'd0, gnt}, {29'd0, exp_g[k]});
        check($sformatf("t3_c%0d_dis", k + 1), {31'd0, cmd}, {31'd0, exp_d[k]});
      end
    join
    repeat (2) @(negedge clock);

    // Locked DMA burst of 160 writes with the CPU waiting.
    snap_we  = we_count;
    snap_lv  = lock_viol;
    dma_lock = 1'b1;
    fork
      begin
        run_master(0, 160, 1'b1, 16'hFE00, 8'h40);
        dma_lock = 1'b0;
        @(negedge clock);
        check("t4_cpu_gnt_l1", {31'd0, gnt[2]}, 32'd0);
        @(negedge clock);
        check("t4_cpu_gnt_l2", {31'd0, gnt[2]}, 32'd1);
      end
      run_master(2, 1, 1'b0, 16'h4000, 8'h00);
    join
    check("t4_we_pulses", we_count - snap_we, 32'd160);
    check("t4_lock_viol", lock_viol - snap_lv, 32'd0);
    repeat (2) @(negedge clock);

    // Starvation: DMA and DBG keep the bus busy; CPU must win the 9th decision.
    first = 0;
    fork
      run_master(0, 5, 1'b0, 16'h5000, 8'h00);
      run_master(1, 4, 1'b1, 16'h6000, 8'h10);
      run_master(2, 1, 1'b0, 16'h7000, 8'h00);
      for (int k = 1; k <= 24; k++) begin
        @(negedge clock);
        if (gnt[2] && first == 0) first = k;
        if (k == 19) check("t5_dma_after_cpu", {31'd0, gnt[0]}, 32'd1);
      end
    join
    check("t5_cpu_grant_cycle", first, 32'd17);
    repeat (2) @(negedge clock);

    // 3-cycle instance: a read to set rdata, then a write that must not disturb it.
    do_reset(1'b1);
    run_master(2, 1, 1'b0, 16'h1234, 8'h00);
    repeat (2) @(negedge clock);
    snap_re = re_count;
    fork
      run_master(2, 1, 1'b1, 16'hFF80, 8'h33);
      begin
        for (int k = 1; k <= 3; k++) begin
          @(negedge clock);
          check($sformatf("t2_c%0d_we", k),    {31'd0, mem_we}, 32'd1);
          check($sformatf("t2_c%0d_wdata", k), {24'd0, mem_wdata}, 32'h33);
          check($sformatf("t2_c%0d_addr", k),  {16'd0, mem_addr}, 32'hFF80);
        end
        @(negedge clock);
        check("t2_c4_done",  {31'd0, done[2]}, 32'd1);
        check("t2_c4_we",    {31'd0, mem_we}, 32'd0);
        check("t2_c4_rdata", {24'd0, rdata}, {24'd0, mem_f(16'h1234)});
      end
    join
    check("t2_no_re", re_count - snap_re, 32'd0);
    repeat (2) @(negedge clock);

    // Reset during the second cycle of a 3-cycle DBG write.
    addr[1] = 16'h8000; wdata[1] = 8'h77; we[1] = 1'b1; req[1] = 1'b1;
    @(negedge clock);
    check("t6_c1_gnt", {29'd0, gnt}, 32'd2);
    check("t6_c1_we",  {31'd0, mem_we}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t6_c3_gnt",  {29'd0, gnt}, 32'd0);
    check("t6_c3_we",   {31'd0, mem_we}, 32'd0);
    check("t6_c3_done", {29'd0, done}, 32'd0);
    reset  = 1'b0;
    req[1] = 1'b0;
    repeat (5) begin
      @(negedge clock);
      check("t6_no_dbg_done", {31'd0, done[1]}, 32'd0);
    end
    run_master(2, 1, 1'b0, 16'h2000, 8'h00);
    repeat (2) @(negedge clock);

    check("sb_empty", q_dma.size() + q_dbg.size() + q_cpu.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
